// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem read issue, return FIFO, halt/redirect.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_unit #(
  parameter int              ADDR_W     = 16,
  parameter int              INSTR_W    = 16,
  parameter int              PC_INC     = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              BUF_DEPTH  = 2,
  parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  output logic               hlt
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  typedef enum logic {RUN, HALT} state_t;

  state_t state_q, state_d;

  logic [INSTR_W-1:0] buf_instr [BUF_DEPTH];
  logic [ADDR_W-1:0]  buf_pc    [BUF_DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;

  logic               ret_valid;
  logic               ret_hlt;
  logic               push;
  logic               pop;
  logic               pop_hlt;
  logic               credit;
  logic               issue;
  logic [CNT_W:0]     used;

  function automatic logic [PTR_W-1:0] nxt_ptr(
    input logic [PTR_W-1:0] p
  );
    if (p == LAST) return '0;
    return p + 1'b1;
  endfunction

  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? buf_instr[head_q] : '0;
  assign out_pc    = out_valid ? buf_pc[head_q] : '0;

  always_comb begin
    pop       = out_valid && out_ready;
    pop_hlt   = pop && (out_instr[INSTR_W-1 -: 4] == HLT_OPCODE);
    ret_valid = imem_rd_en && (state_q == RUN);
    ret_hlt   = ret_valid &&
                (imem_instr[INSTR_W-1 -: 4] == HLT_OPCODE);
    push      = ret_valid && !redirect_valid;
    // A pop this cycle frees its slot before the new fetch returns.
    used      = {1'b0, count_q}
              + (CNT_W+1)'(imem_rd_en)
              - (CNT_W+1)'(pop);
    credit    = (used < DEPTH_V);
    issue     = (state_q == RUN) && !stall && !redirect_valid
              && !ret_hlt && credit;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (ret_hlt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (redirect_valid) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc         <= RESET_PC;
      imem_rd_en <= 1'b0;
      imem_addr  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      hlt        <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_rd_en <= issue;
      if (issue) begin
        imem_addr <= pc;
        pc        <= pc + INC;
      end
      if (redirect_valid) begin
        pc      <= redirect_pc;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        hlt     <= 1'b0;
      end else begin
        if (push) tail_q <= nxt_ptr(tail_q);
        if (pop)  head_q <= nxt_ptr(head_q);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        if (pop_hlt) hlt <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_instr[tail_q] <= imem_instr;
      buf_pc[tail_q]    <= imem_addr;
    end
  end

`ifdef FETCH_PERF_EN
  logic blocked;

  assign blocked = (state_q == RUN) && !redirect_valid
                 && (stall || !credit);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (blocked && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus random
// ready/stall/redirect traffic checked against an address-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] pc;
  logic        hlt;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic [15:0] mem [65536];
  assign imem_instr = mem[imem_addr];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .pc             (pc),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .hlt            (hlt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  logic [15:0] nxt;
  bit          mdl_halt;
  bit          hlt_exp;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected stream: consecutive words from the start address up to
  // and including the first halt word.
  function automatic void top_up();
    exp_t e;
    while (sb.size() < 8 && !mdl_halt) begin
      e.pc    = nxt;
      e.instr = mem[nxt];
      sb.push_back(e);
      if (e.instr[15:12] == 4'hF) mdl_halt = 1'b1;
      nxt = nxt + 16'd1;
    end
  endfunction

  function automatic void restart(input logic [15:0] a);
    sb.delete();
    nxt      = a;
    mdl_halt = 1'b0;
    hlt_exp  = 1'b0;
    top_up();
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("hlt", {31'd0, hlt}, {31'd0, hlt_exp});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc %h, expected none",
                   out_pc);
        end else begin
          me = sb.pop_front();
          chk("out_pc", {16'd0, out_pc}, {16'd0, me.pc});
          chk("out_instr", {16'd0, out_instr}, {16'd0, me.instr});
          pops++;
          if (me.instr[15:12] == 4'hF) hlt_exp = 1'b1;
          top_up();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    restart(16'h0000);
  endtask

  task automatic do_redirect(input logic [15:0] a);
    redirect_pc    = a;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    restart(a);
  endtask

  task automatic chk_rd(input string name, input logic en,
                        input logic [15:0] a);
    chk({name, "_rd_en"}, {31'd0, imem_rd_en}, {31'd0, en});
    if (en) chk({name, "_addr"}, {16'd0, imem_addr}, {16'd0, a});
  endtask

  initial begin
    int p0;
`ifdef FETCH_PERF_EN
    logic [31:0] f0, s0;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) + 16'h1000;

    // 1: reset state and streaming
    out_ready = 1'b1;
    do_reset();
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", {16'd0, out_instr}, 32'd0);
    chk("rst_out_pc", {16'd0, out_pc}, 32'd0);
    tick();
    chk_rd("t1_c1", 1'b1, 16'h0000);
    chk("t1_c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_rd("t1_c2", 1'b1, 16'h0001);
    chk("t1_c2_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_c2_instr", {16'd0, out_instr}, 32'h1000);
    tick();
    chk_rd("t1_c3", 1'b1, 16'h0002);
    chk("t1_c3_out_pc", {16'd0, out_pc}, 32'd1);
    repeat (6) tick();

    // 2: backpressure fills the buffer, then drains in order
    out_ready = 1'b0;
    do_reset();
    tick();
    chk_rd("t2_c1", 1'b1, 16'h0000);
    tick();
    chk_rd("t2_c2", 1'b1, 16'h0001);
    tick();
    chk_rd("t2_c3", 1'b0, 16'h0000);
    chk("t2_pc", {16'd0, pc}, 32'd2);
    tick();
    chk_rd("t2_c4", 1'b0, 16'h0000);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    repeat (10) tick();

    // 3: redirect with data buffered and a fetch in flight
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    do_redirect(16'h0040);
    chk("t3_valid", {31'd0, out_valid}, 32'd0);
    chk_rd("t3_c1", 1'b0, 16'h0000);
    tick();
    chk_rd("t3_c2", 1'b1, 16'h0040);
    out_ready = 1'b1;
    tick();
    chk("t3_out_pc", {16'd0, out_pc}, 32'h40);
    repeat (6) tick();

    // 4: halt word at address 3
    mem[3] = 16'hF000;
    out_ready = 1'b1;
    do_reset();
    repeat (8) tick();
    chk("t4_hlt", {31'd0, hlt}, 32'd1);
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    repeat (4) begin
      chk_rd("t4_idle", 1'b0, 16'h0000);
      tick();
    end
    do_redirect(16'h0000);
    chk("t4_hlt_clr", {31'd0, hlt}, 32'd0);
    tick();
    chk_rd("t4_restart", 1'b1, 16'h0000);
    repeat (10) tick();
    mem[3] = 16'h1003;

    // 5: address wrap
    do_redirect(16'hFFFF);
    tick();
    chk_rd("t5_a", 1'b1, 16'hFFFF);
    tick();
    chk_rd("t5_b", 1'b1, 16'h0000);
    tick();
    chk_rd("t5_c", 1'b1, 16'h0001);
    repeat (4) tick();

    // 6: three-cycle stall mid-stream
    do_redirect(16'h0020);
    tick();
    tick();
    tick();
`ifdef FETCH_PERF_EN
    f0 = perf_fetch_cnt;
    s0 = perf_stall_cnt;
`endif
    stall = 1'b1;
    tick();
    chk_rd("t6_s1", 1'b0, 16'h0000);
    chk("t6_s1_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk_rd("t6_s2", 1'b0, 16'h0000);
    tick();
    chk_rd("t6_s3", 1'b0, 16'h0000);
    stall = 1'b0;
    tick();
    chk_rd("t6_resume", 1'b1, 16'h0023);
`ifdef FETCH_PERF_EN
    chk("t6_perf_stall", perf_stall_cnt - s0, 32'd3);
    chk("t6_perf_fetch", perf_fetch_cnt - f0, 32'd1);
    tick();
    tick();
    chk("t6_perf_fetch2", perf_fetch_cnt - f0, 32'd3);
    chk("t6_perf_stall2", perf_stall_cnt - s0, 32'd3);
`endif
    repeat (4) tick();

    // random traffic with planted halts
    for (int a = 0; a < 512; a++) mem[a] = 16'($urandom) & 16'h7FFF;
    for (int k = 0; k < 6; k++)
      mem[16'h80 + 16'($urandom_range(0, 127))] = 16'hF000 | 16'(k);
    do_redirect(16'h0000);
    for (int c = 0; c < 2000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 40) == 0)
        do_redirect(16'($urandom_range(0, 255)));
      else
        tick();
    end

    // liveness on a halt-free region
    stall     = 1'b0;
    out_ready = 1'b1;
    do_redirect(16'h0010);
    p0 = pops;
    repeat (20) tick();
    chk("liveness", {31'd0, (pops - p0) >= 15}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
